// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// Holds the decoded-class enum, the major opcodes, the legality cause codes,
// the registered field bundle and a signed-range helper.
package rv32i_pkg;

  typedef enum logic [3:0] {
    CLS_R       = 4'd0,
    CLS_I_ALU   = 4'd1,
    CLS_I_SHIFT = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_LOAD    = 4'd4,
    CLS_LUI     = 4'd5,
    CLS_AUIPC   = 4'd6,
    CLS_BRANCH  = 4'd7,
    CLS_JALR    = 4'd8,
    CLS_JAL     = 4'd9
  } instr_class_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_CLASS = 3'd1;
  localparam logic [2:0] ERR_FUNCT = 3'd2;
  localparam logic [2:0] ERR_IMM   = 3'd3;
  localparam logic [2:0] ERR_ALIGN = 3'd4;

  typedef struct packed {
    logic [3:0]  cls;
    logic [2:0]  funct3;
    logic        alt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } bundle_t;

  // True when v is representable as a two's-complement value of 'bits' bits,
  // i.e. everything from bit bits-1 upward is a copy of the sign.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/rv32i_instr_encoder_if.sv
// Field-bundle input handshake and IMEM write port of the encoder.
//   in_*   : decoded fields with valid/ready
//   imem_* : write strobe, byte address, data, and write-ready back-pressure
// slave = encoder side, master = producer / memory side.
interface rv32i_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_class;
  logic [2:0]  in_funct3;
  logic        in_alt;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic [31:0] in_imm;
  logic        imem_we;
  logic        imem_wready;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;

  modport master (
    output in_valid, in_class, in_funct3, in_alt, in_rs1, in_rs2, in_rd, in_imm,
    input  in_ready,
    input  imem_we, imem_waddr, imem_wdata,
    output imem_wready
  );

  modport slave (
    input  in_valid, in_class, in_funct3, in_alt, in_rs1, in_rs2, in_rd, in_imm,
    output in_ready,
    output imem_we, imem_waddr, imem_wdata,
    input  imem_wready
  );
endinterface

// File: rtl/rv32i_field_pack.sv
// Combinational packer: turns one decoded field bundle into a 32-bit RV32I
// word and reports its legality.
//   b     : field bundle
//   word  : packed instruction (don't-care when illegal)
//   legal : bundle may be written
//   code  : first failing check (ERR_NONE when legal)
module rv32i_field_pack
  import rv32i_pkg::*;
(
  input  bundle_t     b,
  output logic [31:0] word,
  output logic        legal,
  output logic [2:0]  code
);

  instr_class_e cls;
  logic [31:0]  imm;
  logic [2:0]   f3;
  logic         cls_bad, f3_bad, imm_bad, odd;

  assign cls = instr_class_e'(b.cls);
  assign imm = b.imm;
  assign f3  = b.funct3;

  always_comb begin
    word    = '0;
    cls_bad = 1'b0;
    f3_bad  = 1'b0;
    imm_bad = 1'b0;
    odd     = 1'b0;
    case (cls)
      CLS_R: begin
        word   = {1'b0, b.alt, 5'b0, b.rs2, b.rs1, f3, b.rd, OP_R};
        f3_bad = b.alt && !(f3 == 3'b000 || f3 == 3'b101);
      end
      CLS_I_ALU: begin
        word    = {imm[11:0], b.rs1, f3, b.rd, OP_I_ALU};
        f3_bad  = (f3 == 3'b001) || (f3 == 3'b101);
        imm_bad = !fits_signed(imm, 12);
      end
      CLS_I_SHIFT: begin
        word    = {1'b0, b.alt, 5'b0, imm[4:0], b.rs1, f3, b.rd, OP_I_ALU};
        f3_bad  = !((f3 == 3'b001 && !b.alt) || f3 == 3'b101);
        imm_bad = (imm[31:5] != '0);
      end
      CLS_STORE: begin
        word    = {imm[11:5], b.rs2, b.rs1, f3, imm[4:0], OP_STORE};
        f3_bad  = (f3 > 3'b010);
        imm_bad = !fits_signed(imm, 12);
      end
      CLS_LOAD: begin
        word    = {imm[11:0], b.rs1, f3, b.rd, OP_LOAD};
        f3_bad  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        imm_bad = !fits_signed(imm, 12);
      end
      CLS_LUI: begin
        word    = {imm[31:12], b.rd, OP_LUI};
        imm_bad = (imm[11:0] != '0);
      end
      CLS_AUIPC: begin
        word    = {imm[31:12], b.rd, OP_AUIPC};
        imm_bad = (imm[11:0] != '0);
      end
      CLS_BRANCH: begin
        word    = {imm[12], imm[10:5], b.rs2, b.rs1, f3, imm[4:1], imm[11], OP_BRANCH};
        f3_bad  = (f3 == 3'b010) || (f3 == 3'b011);
        imm_bad = !fits_signed(imm, 13);
        odd     = imm[0];
      end
      CLS_JALR: begin
        // funct3 is fixed at 000 regardless of what the producer supplied
        word    = {imm[11:0], b.rs1, 3'b000, b.rd, OP_JALR};
        imm_bad = !fits_signed(imm, 12);
      end
      CLS_JAL: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], b.rd, OP_JAL};
        imm_bad = !fits_signed(imm, 21);
        odd     = imm[0];
      end
      default: cls_bad = 1'b1;
    endcase
  end

  always_comb begin
    if (cls_bad)      code = ERR_CLASS;
    else if (f3_bad)  code = ERR_FUNCT;
    else if (imm_bad) code = ERR_IMM;
    else if (odd)     code = ERR_ALIGN;
    else              code = ERR_NONE;
  end

  assign legal = (code == ERR_NONE);

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Two-stage RV32I encoder feeding an IMEM write port.
//   clk, reset (async, active-low), clear (sync restart)
//   bus       : field-bundle handshake + IMEM write port
//   full      : DEPTH words written, further bundles stall
//   err_pulse : one cycle as an illegal bundle retires; err_code holds cause
//   word_cnt / err_cnt : saturating counts of written / rejected bundles
// S1 registers the bundle, S2 registers the packed word and its legality.
module rv32i_instr_encoder
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  rv32i_instr_encoder_if.slave bus,
  output logic                 full,
  output logic                 err_pulse,
  output logic [2:0]           err_code,
  output logic [15:0]          word_cnt,
  output logic [15:0]          err_cnt
);

  bundle_t     s1_q;
  logic        s1_valid;
  logic        s2_valid, s2_legal;
  logic [31:0] s2_word;
  logic [2:0]  s2_code;
  logic [31:0] pack_word;
  logic        pack_legal;
  logic [2:0]  pack_code;
  logic [31:0] waddr_q;
  logic        full_q;
  logic [2:0]  err_code_q;
  logic        wr_done, s2_done, s2_free, s1_adv, accept;

  rv32i_field_pack u_pack (
    .b     (s1_q),
    .word  (pack_word),
    .legal (pack_legal),
    .code  (pack_code)
  );

  // Once full, a legal entry already in S2 parks there until clear/reset.
  assign bus.imem_we    = s2_valid && s2_legal && !full_q && !clear;
  assign wr_done        = bus.imem_we && bus.imem_wready;
  assign err_pulse      = s2_valid && !s2_legal && !clear;
  assign s2_done        = wr_done || err_pulse;
  assign s2_free        = !s2_valid || s2_done;
  assign s1_adv         = s1_valid && s2_free;
  assign bus.in_ready   = !full_q && !clear && (!s1_valid || s2_free);
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = s2_word;
  assign full           = full_q;
  assign err_code       = err_pulse ? s2_code : err_code_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_legal <= 1'b0;
      s2_word  <= '0;
      s2_code  <= ERR_NONE;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1_q.cls    <= bus.in_class;
        s1_q.funct3 <= bus.in_funct3;
        s1_q.alt    <= bus.in_alt;
        s1_q.rs1    <= bus.in_rs1;
        s1_q.rs2    <= bus.in_rs2;
        s1_q.rd     <= bus.in_rd;
        s1_q.imm    <= bus.in_imm;
        s1_valid    <= 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_adv) begin
        s2_valid <= 1'b1;
        s2_legal <= pack_legal;
        s2_word  <= pack_word;
        s2_code  <= pack_code;
      end else if (s2_done) begin
        s2_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waddr_q    <= BASE_ADDR;
      word_cnt   <= '0;
      err_cnt    <= '0;
      full_q     <= 1'b0;
      err_code_q <= ERR_NONE;
    end else if (clear) begin
      waddr_q  <= BASE_ADDR;
      word_cnt <= '0;
      err_cnt  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (wr_done) begin
        waddr_q <= waddr_q + 32'd4;
        if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
        if ({16'h0, word_cnt} + 32'd1 == DEPTH) full_q <= 1'b1;
      end
      if (err_pulse) begin
        err_code_q <= s2_code;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
`timescale 1ns/1ps
module tb_rv32i_instr_encoder;
  import rv32i_pkg::*;

  localparam logic [31:0] BASE_M = 32'h0000_1000;
  localparam logic [31:0] BASE_S = 32'h0000_0200;

  int checks = 0;
  int errors = 0;

  task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    errors++;
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_m, rst_s, clr_m, clr_s;
  logic full_m, ep_m, full_s, ep_s;
  logic [2:0] ec_m, ec_s;
  logic [15:0] wc_m, ecnt_m, wc_s, ecnt_s;

  rv32i_instr_encoder_if bm();
  rv32i_instr_encoder_if bs();

  rv32i_instr_encoder #(.DEPTH(1024), .BASE_ADDR(BASE_M)) dut_m (
    .clk(clk), .reset(rst_m), .clear(clr_m), .bus(bm.slave),
    .full(full_m), .err_pulse(ep_m), .err_code(ec_m), .word_cnt(wc_m), .err_cnt(ecnt_m));

  rv32i_instr_encoder #(.DEPTH(4), .BASE_ADDR(BASE_S)) dut_s (
    .clk(clk), .reset(rst_s), .clear(clr_s), .bus(bs.slave),
    .full(full_s), .err_pulse(ep_s), .err_code(ec_s), .word_cnt(wc_s), .err_cnt(ecnt_s));

  typedef struct { logic [31:0] word; int code; } exp_t;
  exp_t exp_q[$];
  int legal_sent = 0, illegal_sent = 0;

  function automatic longint fld(input logic [31:0] v, input int hi, input int lo);
    return (longint'(v) >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
  endfunction

  function automatic void model(input int cls, input int f3, input bit alt, input int rs1,
                                input int rs2, input int rd, input logic [31:0] imm,
                                output logic [31:0] word, output int code);
    longint si = longint'($signed(imm));
    longint w = 0;
    longint r1 = longint'(rs1) << 15;
    longint r2 = longint'(rs2) << 20;
    longint rdd = longint'(rd) << 7;
    longint f = longint'(f3) << 12;
    longint a = alt ? (longint'(1) << 30) : 0;
    bit f3bad = 0, immbad = 0, odd = 0;
    bit in12 = (si >= -2048) && (si <= 2047);
    case (cls)
      0: begin f3bad = alt && f3 != 0 && f3 != 5; w = a + r2 + r1 + f + rdd + 'h33; end
      1: begin f3bad = (f3 == 1 || f3 == 5); immbad = !in12;
               w = (fld(imm, 11, 0) << 20) + r1 + f + rdd + 'h13; end
      2: begin f3bad = !((f3 == 1 && !alt) || f3 == 5); immbad = (si < 0 || si > 31);
               w = a + (fld(imm, 4, 0) << 20) + r1 + f + rdd + 'h13; end
      3: begin f3bad = f3 > 2; immbad = !in12;
               w = (fld(imm, 11, 5) << 25) + r2 + r1 + f + (fld(imm, 4, 0) << 7) + 'h23; end
      4: begin f3bad = (f3 == 3 || f3 >= 6); immbad = !in12;
               w = (fld(imm, 11, 0) << 20) + r1 + f + rdd + 'h03; end
      5: begin immbad = fld(imm, 11, 0) != 0; w = (fld(imm, 31, 12) << 12) + rdd + 'h37; end
      6: begin immbad = fld(imm, 11, 0) != 0; w = (fld(imm, 31, 12) << 12) + rdd + 'h17; end
      7: begin f3bad = (f3 == 2 || f3 == 3); immbad = (si < -4096 || si > 4095); odd = imm[0];
               w = (fld(imm, 12, 12) << 31) + (fld(imm, 10, 5) << 25) + r2 + r1 + f
                   + (fld(imm, 4, 1) << 8) + (fld(imm, 11, 11) << 7) + 'h63; end
      8: begin immbad = !in12; w = (fld(imm, 11, 0) << 20) + r1 + rdd + 'h67; end
      9: begin immbad = (si < -(longint'(1) << 20) || si > (longint'(1) << 20) - 1); odd = imm[0];
               w = (fld(imm, 20, 20) << 31) + (fld(imm, 10, 1) << 21) + (fld(imm, 11, 11) << 20)
                   + (fld(imm, 19, 12) << 12) + rdd + 'h6F; end
      default: w = 0;
    endcase
    code = (cls > 9) ? 1 : f3bad ? 2 : immbad ? 3 : odd ? 4 : 0;
    word = w[31:0];
  endfunction

  logic [31:0] exp_addr = BASE_M;
  logic [31:0] wr_data_log[$];
  int wr_cyc[$];
  int cyc = 0;
  bit stall_prev = 0;
  logic [31:0] stall_data, stall_addr;
  bit has;

  always @(negedge clk) begin
    cyc++;
    if (rst_m && bm.imem_we) begin
      has = exp_q.size() != 0;
      checks++; if (has !== 1'b1) fail("wr_pending", has, 1);
      if (has) begin
        checks++; if (exp_q[0].code !== 0) fail("wr_legal", exp_q[0].code, 0);
        checks++; if (bm.imem_wdata !== exp_q[0].word) fail("wr_data", bm.imem_wdata, exp_q[0].word);
      end
      checks++; if (bm.imem_waddr !== exp_addr) fail("wr_addr", bm.imem_waddr, exp_addr);
      if (stall_prev) begin
        checks++; if (bm.imem_wdata !== stall_data) fail("stall_data", bm.imem_wdata, stall_data);
        checks++; if (bm.imem_waddr !== stall_addr) fail("stall_addr", bm.imem_waddr, stall_addr);
      end
      stall_prev = !bm.imem_wready;
      stall_data = bm.imem_wdata;
      stall_addr = bm.imem_waddr;
      if (bm.imem_wready) begin
        if (has) void'(exp_q.pop_front());
        exp_addr += 32'd4;
        wr_data_log.push_back(bm.imem_wdata);
        wr_cyc.push_back(cyc);
      end
    end else begin
      stall_prev = 0;
    end
    if (rst_m && ep_m) begin
      has = exp_q.size() != 0;
      checks++; if (has !== 1'b1) fail("err_pending", has, 1);
      if (has) begin
        checks++; if (32'(ec_m) !== exp_q[0].code) fail("err_code_pulse", ec_m, exp_q[0].code);
        void'(exp_q.pop_front());
      end
    end
  end

  bit rand_wr = 0;
  bit wr_hold = 1;
  initial begin
    bm.imem_wready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (rand_wr) bm.imem_wready = ($urandom_range(0, 3) != 0);
      else bm.imem_wready = wr_hold;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic send_m(input int cls, input int f3, input bit alt, input int rs1,
                        input int rs2, input int rd, input logic [31:0] imm);
    logic [31:0] w; int c; bit acc;
    bm.in_class = cls[3:0]; bm.in_funct3 = f3[2:0]; bm.in_alt = alt;
    bm.in_rs1 = rs1[4:0]; bm.in_rs2 = rs2[4:0]; bm.in_rd = rd[4:0]; bm.in_imm = imm;
    bm.in_valid = 1'b1;
    acc = 0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk); acc = bm.in_ready;
      @(posedge clk); #1;
    end
    bm.in_valid = 1'b0;
    checks++; if (acc !== 1'b1) fail("accept_timeout", acc, 1);
    if (acc) begin
      model(cls, f3, alt, rs1, rs2, rd, imm, w, c);
      exp_q.push_back('{w, c});
      if (c == 0) legal_sent++; else illegal_sent++;
    end
  endtask

  task automatic drain_m();
    int k = 0;
    while (exp_q.size() != 0 && k < 500) begin @(posedge clk); #1; k++; end
    checks++; if (exp_q.size() !== 0) fail("drain", exp_q.size(), 0);
  endtask

  task automatic send_s(input int cls, input int f3, input int rd, input logic [31:0] imm,
                        input int budget, output bit acc);
    bs.in_class = cls[3:0]; bs.in_funct3 = f3[2:0]; bs.in_alt = 1'b0;
    bs.in_rs1 = 5'd0; bs.in_rs2 = 5'd0; bs.in_rd = rd[4:0]; bs.in_imm = imm;
    bs.in_valid = 1'b1;
    acc = 0;
    for (int k = 0; k < budget && !acc; k++) begin
      @(negedge clk); acc = bs.in_ready;
      @(posedge clk); #1;
    end
    bs.in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] imm, w;
    int c, n, cls, k;
    bit acc;

    rst_m = 0; rst_s = 0; clr_m = 0; clr_s = 0;
    bm.in_valid = 0; bm.in_class = 0; bm.in_funct3 = 0; bm.in_alt = 0;
    bm.in_rs1 = 0; bm.in_rs2 = 0; bm.in_rd = 0; bm.in_imm = 0;
    bs.in_valid = 0; bs.in_class = 0; bs.in_funct3 = 0; bs.in_alt = 0;
    bs.in_rs1 = 0; bs.in_rs2 = 0; bs.in_rd = 0; bs.in_imm = 0;
    bs.imem_wready = 1'b1;
    #22;
    @(posedge clk); #1; rst_m = 1; rst_s = 1;

    @(negedge clk);
    checks++; if (bm.in_ready !== 1'b1) fail("rst_in_ready", bm.in_ready, 1);
    checks++; if (bm.imem_we !== 1'b0) fail("rst_we", bm.imem_we, 0);
    checks++; if (bm.imem_waddr !== BASE_M) fail("rst_waddr", bm.imem_waddr, BASE_M);
    checks++; if (bm.imem_wdata !== 32'h0) fail("rst_wdata", bm.imem_wdata, 0);
    checks++; if (full_m !== 1'b0) fail("rst_full", full_m, 0);
    checks++; if (ep_m !== 1'b0) fail("rst_err_pulse", ep_m, 0);
    checks++; if (ec_m !== 3'd0) fail("rst_err_code", ec_m, 0);
    checks++; if (wc_m !== 16'd0) fail("rst_word_cnt", wc_m, 0);
    checks++; if (ecnt_m !== 16'd0) fail("rst_err_cnt", ecnt_m, 0);
    @(posedge clk); #1;

    send_m(1, 0, 0, 0, 0, 1, 32'd5);
    @(negedge clk);
    checks++; if (bm.imem_we !== 1'b0) fail("lat_we_c1", bm.imem_we, 0);
    @(negedge clk);
    checks++; if (bm.imem_we !== 1'b1) fail("lat_we_c2", bm.imem_we, 1);
    checks++; if (bm.imem_wdata !== 32'h00500093) fail("addi_word", bm.imem_wdata, 32'h00500093);
    checks++; if (bm.imem_waddr !== BASE_M) fail("addi_addr", bm.imem_waddr, BASE_M);
    @(posedge clk); #1;

    send_m(0, 0, 0, 1, 2, 3, 32'd0);
    send_m(3, 2, 0, 1, 2, 0, 32'd8);
    drain_m();
    n = wr_data_log.size();
    checks++; if (wr_data_log[n-2] !== 32'h002081B3) fail("add_word", wr_data_log[n-2], 32'h002081B3);
    checks++; if (wr_data_log[n-1] !== 32'h0020A423) fail("sw_word", wr_data_log[n-1], 32'h0020A423);
    checks++; if (wr_cyc[n-1] - wr_cyc[n-2] !== 1) fail("b2b_cycles", wr_cyc[n-1] - wr_cyc[n-2], 1);

    send_m(7, 0, 0, 1, 2, 0, 32'd8);
    send_m(9, 0, 0, 0, 0, 1, 32'd16);
    send_m(5, 0, 0, 0, 0, 5, 32'h12345000);
    drain_m();
    n = wr_data_log.size();
    checks++; if (wr_data_log[n-3] !== 32'h00208463) fail("beq_word", wr_data_log[n-3], 32'h00208463);
    checks++; if (wr_data_log[n-2] !== 32'h010000EF) fail("jal_word", wr_data_log[n-2], 32'h010000EF);
    checks++; if (wr_data_log[n-1] !== 32'h123452B7) fail("lui_word", wr_data_log[n-1], 32'h123452B7);

    n = wr_data_log.size();
    send_m(7, 0, 0, 1, 2, 0, 32'd7);
    drain_m();
    checks++; if (ec_m !== 3'd4) fail("odd_branch_code", ec_m, 4);
    checks++; if (ecnt_m !== 16'd1) fail("odd_branch_cnt", ecnt_m, 1);
    checks++; if (wr_data_log.size() !== n) fail("odd_branch_nowrite", wr_data_log.size(), n);
    send_m(1, 0, 0, 0, 0, 1, 32'd4096);
    drain_m();
    checks++; if (ec_m !== 3'd3) fail("imm_range_code", ec_m, 3);
    checks++; if (ecnt_m !== 16'd2) fail("imm_range_cnt", ecnt_m, 2);

    wr_hold = 0;
    send_m(0, 0, 1, 4, 5, 6, 32'd0);
    send_m(4, 2, 0, 7, 0, 8, -32'sd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bm.in_ready !== 1'b0) fail("stall_in_ready", bm.in_ready, 0);
      checks++; if (bm.imem_we !== 1'b1) fail("stall_we", bm.imem_we, 1);
    end
    @(posedge clk); #1;
    wr_hold = 1;
    send_m(2, 5, 1, 9, 0, 10, 32'd31);
    drain_m();
    checks++; if (32'(wc_m) !== legal_sent) fail("stall_word_cnt", wc_m, legal_sent);
    checks++; if (32'(ecnt_m) !== illegal_sent) fail("stall_err_cnt", ecnt_m, illegal_sent);

    rand_wr = 1;
    for (int i = 0; i < 150; i++) begin
      cls = $urandom_range(0, 11);
      case ($urandom_range(0, 5))
        0: imm = 32'($urandom_range(0, 31));
        1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        2: imm = $urandom;
        3: imm = $urandom & 32'hFFFF_F000;
        4: begin imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                 if ($urandom_range(0, 3) != 0) imm[0] = 1'b0; end
        default: begin imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
                 if ($urandom_range(0, 3) != 0) imm[0] = 1'b0; end
      endcase
      send_m(cls, $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), imm);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    rand_wr = 0;
    wr_hold = 1;
    drain_m();
    checks++; if (32'(wc_m) !== legal_sent) fail("rand_word_cnt", wc_m, legal_sent);
    checks++; if (32'(ecnt_m) !== illegal_sent) fail("rand_err_cnt", ecnt_m, illegal_sent);
    checks++; if (full_m !== 1'b0) fail("rand_full", full_m, 0);
    checks++; if (bm.imem_waddr !== BASE_M + 32'(legal_sent * 4))
      fail("rand_waddr", bm.imem_waddr, BASE_M + 32'(legal_sent * 4));

    for (int i = 0; i < 4; i++) begin
      send_s(1, 0, 1, 32'(i + 1), 50, acc);
      checks++; if (acc !== 1'b1) fail("fill_accept", acc, 1);
    end
    k = 0;
    while (wc_s != 16'd4 && k < 20) begin @(posedge clk); #1; k++; end
    checks++; if (wc_s !== 16'd4) fail("fill_word_cnt", wc_s, 4);
    checks++; if (full_s !== 1'b1) fail("fill_full", full_s, 1);
    checks++; if (bs.imem_waddr !== BASE_S + 32'd16) fail("fill_waddr", bs.imem_waddr, BASE_S + 32'd16);
    send_s(1, 0, 1, 32'd9, 8, acc);
    checks++; if (acc !== 1'b0) fail("fifth_stalls", acc, 0);
    @(negedge clk);
    checks++; if (bs.imem_we !== 1'b0) fail("fifth_no_we", bs.imem_we, 0);
    checks++; if (wc_s !== 16'd4) fail("fifth_word_cnt", wc_s, 4);
    @(posedge clk); #1; clr_s = 1;
    @(negedge clk);
    checks++; if (bs.in_ready !== 1'b0) fail("clear_in_ready", bs.in_ready, 0);
    @(posedge clk); #1; clr_s = 0;
    @(negedge clk);
    checks++; if (full_s !== 1'b0) fail("clear_full", full_s, 0);
    checks++; if (wc_s !== 16'd0) fail("clear_word_cnt", wc_s, 0);
    checks++; if (bs.imem_waddr !== BASE_S) fail("clear_waddr", bs.imem_waddr, BASE_S);
    @(posedge clk); #1;
    send_s(1, 0, 2, 32'd7, 10, acc);
    model(1, 0, 0, 0, 0, 2, 32'd7, w, c);
    @(negedge clk);
    @(negedge clk);
    checks++; if (bs.imem_we !== 1'b1) fail("post_clear_we", bs.imem_we, 1);
    checks++; if (bs.imem_waddr !== BASE_S) fail("post_clear_addr", bs.imem_waddr, BASE_S);
    checks++; if (bs.imem_wdata !== w) fail("post_clear_data", bs.imem_wdata, w);
    @(posedge clk); #1;
    checks++; if (wc_s !== 16'd1) fail("post_clear_cnt", wc_s, 1);

    bs.imem_wready = 1'b0;
    send_s(5, 0, 3, 32'hABCDE000, 10, acc);
    @(negedge clk);
    @(negedge clk);
    checks++; if (bs.imem_we !== 1'b1) fail("pre_rst_we", bs.imem_we, 1);
    #2 rst_s = 0;
    #1;
    checks++; if (bs.imem_we !== 1'b0) fail("arst_we", bs.imem_we, 0);
    checks++; if (bs.in_ready !== 1'b1) fail("arst_in_ready", bs.in_ready, 1);
    checks++; if (bs.imem_waddr !== BASE_S) fail("arst_waddr", bs.imem_waddr, BASE_S);
    checks++; if (bs.imem_wdata !== 32'h0) fail("arst_wdata", bs.imem_wdata, 0);
    checks++; if (wc_s !== 16'd0) fail("arst_word_cnt", wc_s, 0);
    checks++; if ({ep_s, ec_s, ecnt_s, full_s} !== 21'd0) fail("arst_err", {ep_s, ec_s, ecnt_s, full_s}, 0);
    @(posedge clk); #1; rst_s = 1; bs.imem_wready = 1'b1;
    @(negedge clk);
    checks++; if (bs.imem_we !== 1'b0) fail("arst_no_replay", bs.imem_we, 0);
    @(posedge clk); #1;
    checks++; if (wc_s !== 16'd0) fail("arst_cnt_after", wc_s, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
- Inverse of the instruction decoder: accepts decoded RV32I fields (class, funct3, alt, rs1/rs2/rd, full-value immediate) and packs them into a 32-bit instruction word.
- Checks field legality, then writes legal words sequentially into IMEM through a write port.
- Used to preload programs and in self-checking benches, giving a round-trip with the decoder.

Parameters:
- DEPTH, 1024: IMEM capacity in words; load limit.
- BASE_ADDR, 32'h0: byte address of the first write.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  sync: restart the load at BASE_ADDR and zero the counters.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept.
- in_class  in  4  instruction class (package enum).
- in_funct3  in  3  funct3.
- in_alt  in  1  funct7[5] for R and shift classes.
- in_rs1, in_rs2, in_rd  in  5 each  register indices.
- in_imm  in  32  immediate as a signed byte value (LUI/AUIPC: full upper value).
- imem_we  out  1  write strobe.
- imem_wready  in  1  IMEM accepts the write.
- imem_waddr  out  32  byte address.
- imem_wdata  out  32  encoded word.
- full  out  1  DEPTH words written.
- err_pulse  out  1  one-cycle illegal-bundle flag.
- err_code  out  3  cause, held until the next error.
- word_cnt  out  16  legal words written.
- err_cnt  out  16  rejected bundles.

Behaviour:
- Reset values: all outputs 0 except imem_waddr=BASE_ADDR and in_ready=1.
- Pipeline, 2 stages, valid/ready:
  - S1 registers the input bundle on in_valid&&in_ready.
  - S2 holds the encoded word plus its legality result.
  - in_ready = !full && !clear && (S1 empty || S1 can advance).
  - Latency accept to imem_we is 2 cycles.
- IMEM write:
  - imem_we = S2 valid && legal. Write completes on imem_we&&imem_wready.
  - While imem_wready=0, S2 holds and stalls S1; data and address stay stable.
  - Illegal S2 entries retire in one cycle without imem_we.
- Address and counters:
  - On each completed write: imem_waddr += 4 and word_cnt += 1.
  - full asserts when word_cnt==DEPTH. Subsequent bundles stall (in_ready=0); no wrap.
  - Counters saturate at 16'hFFFF.
- Encoding:
  - R: funct7 = {0,alt,00000}.
  - I-ALU/Load/JALR: imm[11:0] goes to bits[31:20].
  - Shift: {0,alt,00000, imm[4:0]}.
  - S: split imm[11:5] / imm[4:0].
  - B: {imm[12],imm[10:5]} and {imm[4:1],imm[11]}.
  - U: imm[31:12].
  - J: {imm[20],imm[10:1],imm[11],imm[19:12]}.
  - JALR funct3 is forced to 000.
- Legality checks (err_code), first match wins:
  - 1 = bad class.
  - 2 = illegal funct3/alt:
    - Load accepts 000/001/010/100/101.
    - S accepts 000–010.
    - B rejects 010/011.
    - R accepts alt only with 000/101.
    - I-ALU rejects 001/101 (shift class).
    - Shift accepts 001 with alt=0, or 101.
  - 3 = imm out of range:
    - 12-bit classes require imm[31:11] to be all equal.
    - Shift requires imm[31:5]==0.
    - B requires a 13-bit signed value; J requires 21-bit signed.
    - U requires imm[11:0]==0.
  - 4 = B/J odd offset (imm[0]=1).
- On error: err_pulse for one cycle as the entry retires; err_cnt += 1.
- rd=0 is legal and is encoded as-is.
- clear:
  - Synchronous: flushes S1/S2, resets imem_waddr/word_cnt/err_cnt/full, and deasserts imem_we that cycle.
  - Wins over a simultaneous accept or write completion; that write is not counted.
- Async reset mid-write drops the write immediately; no partial state survives.

Decomposition:
- Package rv32i_pkg holds:
  - The class enum: R, I_ALU, I_SHIFT, STORE, LOAD, LUI, AUIPC, BRANCH, JALR, JAL.
  - Opcode constants 0110011, 0010011, 0100011, 0000011, 0110111, 0010111, 1100011, 1100111, 1101111.
  - err_code constants.
- One sub-module, rv32i_field_pack: purely combinational packing plus legality check, instantiated in S2.
- The top holds the pipeline registers, handshake, address and counters.

Test Plan:
- I_ALU f3=000, rs1=0, rd=1, imm=5 -> imem_wdata=32'h00500093 at addr BASE_ADDR, exactly 2 cycles after accept.
- Back-to-back R add rd=3 rs1=1 rs2=2, then STORE f3=010 rs1=1 rs2=2 imm=8 -> 32'h002081B3 then 32'h0020A423 on consecutive cycles, addr +4.
- BRANCH f3=000 rs1=1 rs2=2 imm=8; JAL rd=1 imm=16; LUI rd=5 imm=32'h12345000 -> 32'h00208463, 32'h010000EF, 32'h123452B7.
- BRANCH imm=7 -> err_pulse, err_code=4, no imem_we, err_cnt=1. I_ALU imm=4096 -> err_code=3.
- imem_wready=0 for 5 cycles during a stream -> imem_wdata/waddr stable, in_ready drops after S1 fills; no loss or duplication on release.
- DEPTH=4: 5 legal bundles -> 4 writes, full=1, 5th stalls. Assert clear -> full=0, next write at BASE_ADDR. Async reset pulse mid-stall -> all outputs at reset values.
